pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: stage/PC enables, RAW-hazard bubbles, fetch/decode flush, HALT drain.
// Latency: enables/bubble/flush are combinational; scoreboard, state, counters update each clk.
// Backpressure: a RAW hazard holds fetch/decode and bubbles execute; HALT drains then freezes all stages.
module pipe_hazard_ctrl #(
  parameter int NSTAGES   = 5,
  parameter int REGW      = 3,
  parameter int FWD       = 0,
  parameter int RF_BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid,
  input  logic [REGW-1:0]    dec_rs_sel,
  input  logic [REGW-1:0]    dec_rt_sel,
  input  logic               dec_rs_used,
  input  logic               dec_rt_used,
  input  logic               dec_wr_en,
  input  logic [REGW-1:0]    dec_wr_sel,
  input  logic               dec_is_load,
  input  logic               dec_halt,
  input  logic               redirect,
  output logic [NSTAGES-2:0] stage_en,
  output logic               pc_en,
  output logic               bubble,
  output logic               flush_fd,
  output logic               halted,
  output logic [15:0]        stall_cnt,
  output logic               err
);

  localparam int NSB     = NSTAGES - 2;
  localparam int HZ_LAST = NSTAGES - 3 - RF_BYPASS;

  typedef struct packed {
    logic            vld;
    logic            wr_en;
    logic [REGW-1:0] wr_sel;
    logic            is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  // sb[0] is the execute stage, sb[NSB-1] is writeback
  sb_entry_t  sb [NSB];
  sb_entry_t  dec_entry;
  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_cnt_nxt;
  logic       hazard, stall, in_run, redirect_ok, sb_load;

  function automatic logic src_match(input sb_entry_t e, input logic used,
                                     input logic [REGW-1:0] sel);
    return used & e.vld & e.wr_en & (e.wr_sel == sel);
  endfunction

  assign dec_entry = '{vld: 1'b1, wr_en: dec_wr_en, wr_sel: dec_wr_sel, is_load: dec_is_load};

  always_comb begin
    hazard = 1'b0;
    if (FWD == 0) begin
      for (int k = 0; k < NSB; k++) begin
        if (k <= HZ_LAST &&
            (src_match(sb[k], dec_rs_used, dec_rs_sel) ||
             src_match(sb[k], dec_rt_used, dec_rt_sel)))
          hazard = 1'b1;
      end
    end else begin
      if (sb[0].is_load &&
          (src_match(sb[0], dec_rs_used, dec_rs_sel) ||
           src_match(sb[0], dec_rt_used, dec_rt_sel)))
        hazard = 1'b1;
    end
  end

  assign in_run      = (state == ST_RUN);
  assign stall       = dec_valid & hazard & in_run;
  assign redirect_ok = dec_valid & redirect & ~stall & in_run;
  assign sb_load     = dec_valid & ~bubble & in_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // the counter reaching zero means HALT has just left writeback
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      ST_RUN: begin
        if (dec_valid && dec_halt && !stall) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = 4'(NSB);
        end
      end
      ST_DRAIN: begin
        drain_cnt_nxt = drain_cnt - 4'd1;
        if (drain_cnt == 4'd1)
          state_nxt = ST_HALTED;
      end
      default: ;
    endcase
  end

  always_comb begin
    stage_en = '1;
    pc_en    = 1'b1;
    bubble   = 1'b0;
    flush_fd = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_RUN: begin
        if (stall) begin
          pc_en       = 1'b0;
          stage_en[0] = 1'b0;
          bubble      = 1'b1;
        end else begin
          flush_fd = redirect_ok;
        end
      end
      ST_DRAIN: begin
        pc_en       = 1'b0;
        stage_en[0] = 1'b0;
        bubble      = 1'b1;
      end
      default: begin
        stage_en = '0;
        pc_en    = 1'b0;
        halted   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSB; k++)
        sb[k] <= '0;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      sb[0] <= sb_load ? dec_entry : '0;
      for (int k = 1; k < NSB; k++)
        sb[k] <= sb[k-1];
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if ((redirect && !dec_valid) || (dec_halt && redirect))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three configurations share one stimulus bus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_rs_used, dec_rt_used, dec_wr_en, dec_is_load, dec_halt, redirect;
  logic [2:0] dec_rs_sel, dec_rt_sel, dec_wr_sel;

  logic [3:0]  d_stage_en, f_stage_en;
  logic [6:0]  s_stage_en;
  logic        d_pc_en, d_bubble, d_flush_fd, d_halted, d_err;
  logic        f_pc_en, f_bubble, f_flush_fd, f_halted, f_err;
  logic        s_pc_en, s_bubble, s_flush_fd, s_halted, s_err;
  logic [15:0] d_stall_cnt, f_stall_cnt, s_stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NSTAGES(5), .REGW(3), .FWD(0), .RF_BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs_sel(dec_rs_sel), .dec_rt_sel(dec_rt_sel),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr_en(dec_wr_en),
    .dec_wr_sel(dec_wr_sel), .dec_is_load(dec_is_load), .dec_halt(dec_halt), .redirect(redirect),
    .stage_en(d_stage_en), .pc_en(d_pc_en), .bubble(d_bubble), .flush_fd(d_flush_fd),
    .halted(d_halted), .stall_cnt(d_stall_cnt), .err(d_err));

  pipe_hazard_ctrl #(.NSTAGES(5), .REGW(3), .FWD(1), .RF_BYPASS(1)) u_fwd (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs_sel(dec_rs_sel), .dec_rt_sel(dec_rt_sel),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr_en(dec_wr_en),
    .dec_wr_sel(dec_wr_sel), .dec_is_load(dec_is_load), .dec_halt(dec_halt), .redirect(redirect),
    .stage_en(f_stage_en), .pc_en(f_pc_en), .bubble(f_bubble), .flush_fd(f_flush_fd),
    .halted(f_halted), .stall_cnt(f_stall_cnt), .err(f_err));

  pipe_hazard_ctrl #(.NSTAGES(8), .REGW(3), .FWD(0), .RF_BYPASS(0)) u_sat (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs_sel(dec_rs_sel), .dec_rt_sel(dec_rt_sel),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr_en(dec_wr_en),
    .dec_wr_sel(dec_wr_sel), .dec_is_load(dec_is_load), .dec_halt(dec_halt), .redirect(redirect),
    .stage_en(s_stage_en), .pc_en(s_pc_en), .bubble(s_bubble), .flush_fd(s_flush_fd),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .err(s_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs_used = 0; dec_rt_used = 0; dec_wr_en = 0; dec_is_load = 0;
    dec_halt = 0; redirect = 0; dec_rs_sel = 0; dec_rt_sel = 0; dec_wr_sel = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic set_writer(input logic [2:0] rd, input logic ld);
    idle();
    dec_valid = 1; dec_wr_en = 1; dec_wr_sel = rd; dec_is_load = ld;
  endtask

  task automatic set_reader(input logic [2:0] rs);
    idle();
    dec_valid = 1; dec_rs_used = 1; dec_rs_sel = rs;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (d_stage_en !== 4'b1111) begin n_fail++; $display("FAIL reset_stage_en got=%b exp=1111", d_stage_en); end
    n_cmp++; if (d_pc_en !== 1'b1) begin n_fail++; $display("FAIL reset_pc_en got=%b exp=1", d_pc_en); end
    n_cmp++; if (d_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got=%b exp=0", d_bubble); end
    n_cmp++; if (d_flush_fd !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", d_flush_fd); end
    n_cmp++; if (d_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", d_halted); end
    n_cmp++; if (d_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", d_stall_cnt); end
    n_cmp++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", d_err); end
    n_cmp++; if (s_stage_en !== 7'h7F) begin n_fail++; $display("FAIL reset_stage_en8 got=%b exp=1111111", s_stage_en); end
  endtask

  task automatic test_raw();
    do_reset();
    set_writer(3'd3, 1'b0);
    #1;
    n_cmp++; if (d_bubble !== 1'b0) begin n_fail++; $display("FAIL raw_writer_bubble got=%b exp=0", d_bubble); end
    tick();
    set_reader(3'd3);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (d_bubble !== 1'b1 || d_pc_en !== 1'b0 || d_stage_en !== 4'b1110) begin
        n_fail++; $display("FAIL raw_stall%0d bubble=%b pc_en=%b stage_en=%b exp 1/0/1110", i, d_bubble, d_pc_en, d_stage_en);
      end
      tick();
    end
    #1;
    n_cmp++; if (d_bubble !== 1'b0 || d_pc_en !== 1'b1) begin
      n_fail++; $display("FAIL raw_release bubble=%b pc_en=%b exp 0/1", d_bubble, d_pc_en);
    end
    tick();
    idle();
    #1;
    n_cmp++; if (d_stall_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_stall_cnt got=%0d exp=2", d_stall_cnt); end
    set_writer(3'd3, 1'b0);
    tick();
    set_reader(3'd5);
    dec_rt_sel = 3'd3;
    #1;
    n_cmp++; if (d_bubble !== 1'b0 || d_pc_en !== 1'b1) begin
      n_fail++; $display("FAIL raw_unused_rt bubble=%b pc_en=%b exp 0/1", d_bubble, d_pc_en);
    end
    tick();
    idle();
    #1;
    n_cmp++; if (d_stall_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_unused_cnt got=%0d exp=2", d_stall_cnt); end
  endtask

  task automatic test_fwd();
    do_reset();
    set_writer(3'd2, 1'b1);
    tick();
    set_reader(3'd2);
    #1;
    n_cmp++; if (f_bubble !== 1'b1 || f_pc_en !== 1'b0) begin
      n_fail++; $display("FAIL fwd_load_use bubble=%b pc_en=%b exp 1/0", f_bubble, f_pc_en);
    end
    tick();
    #1;
    n_cmp++; if (f_bubble !== 1'b0 || f_pc_en !== 1'b1) begin
      n_fail++; $display("FAIL fwd_load_release bubble=%b pc_en=%b exp 0/1", f_bubble, f_pc_en);
    end
    tick();
    set_writer(3'd2, 1'b0);
    tick();
    set_reader(3'd2);
    #1;
    n_cmp++; if (f_bubble !== 1'b0 || f_pc_en !== 1'b1) begin
      n_fail++; $display("FAIL fwd_alu bubble=%b pc_en=%b exp 0/1", f_bubble, f_pc_en);
    end
    tick();
    idle();
    #1;
    n_cmp++; if (f_stall_cnt !== 16'd1) begin n_fail++; $display("FAIL fwd_stall_cnt got=%0d exp=1", f_stall_cnt); end
  endtask

  task automatic test_redirect();
    do_reset();
    idle();
    dec_valid = 1; redirect = 1;
    #1;
    n_cmp++; if (d_flush_fd !== 1'b1 || d_pc_en !== 1'b1) begin
      n_fail++; $display("FAIL redir_plain flush=%b pc_en=%b exp 1/1", d_flush_fd, d_pc_en);
    end
    tick();
    redirect = 0;
    #1;
    n_cmp++; if (d_flush_fd !== 1'b0) begin n_fail++; $display("FAIL redir_one_cycle flush=%b exp=0", d_flush_fd); end
    set_writer(3'd3, 1'b0);
    tick();
    set_reader(3'd3);
    redirect = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (d_flush_fd !== 1'b0 || d_bubble !== 1'b1) begin
        n_fail++; $display("FAIL redir_stall%0d flush=%b bubble=%b exp 0/1", i, d_flush_fd, d_bubble);
      end
      tick();
    end
    #1;
    n_cmp++; if (d_flush_fd !== 1'b1 || d_pc_en !== 1'b1) begin
      n_fail++; $display("FAIL redir_after_stall flush=%b pc_en=%b exp 1/1", d_flush_fd, d_pc_en);
    end
    tick();
    idle();
    #1;
    n_cmp++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL redir_no_err got=%b exp=0", d_err); end
    redirect = 1;
    tick();
    redirect = 0;
    #1;
    n_cmp++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL err_set got=%b exp=1", d_err); end
    tick();
    tick();
    n_cmp++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", d_err); end
    do_reset();
    #1;
    n_cmp++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got=%b exp=0", d_err); end
    dec_valid = 1; dec_halt = 1; redirect = 1;
    tick();
    idle();
    #1;
    n_cmp++; if (d_err !== 1'b1) begin n_fail++; $display("FAIL err_halt_redirect got=%b exp=1", d_err); end
  endtask

  task automatic test_halt();
    do_reset();
    idle();
    dec_valid = 1; dec_halt = 1;
    #1;
    n_cmp++; if (d_pc_en !== 1'b1 || d_stage_en !== 4'b1111) begin
      n_fail++; $display("FAIL halt_t pc_en=%b stage_en=%b exp 1/1111", d_pc_en, d_stage_en);
    end
    tick();
    idle();
    #1;
    n_cmp++; if (d_pc_en !== 1'b0 || d_bubble !== 1'b1 || d_stage_en !== 4'b1110) begin
      n_fail++; $display("FAIL halt_drain pc_en=%b bubble=%b stage_en=%b exp 0/1/1110", d_pc_en, d_bubble, d_stage_en);
    end
    tick();
    tick();
    n_cmp++; if (d_halted !== 1'b0 || d_stage_en !== 4'b1110) begin
      n_fail++; $display("FAIL halt_t3 halted=%b stage_en=%b exp 0/1110", d_halted, d_stage_en);
    end
    tick();
    n_cmp++; if (d_halted !== 1'b1 || d_stage_en !== 4'b0000 || d_pc_en !== 1'b0 || d_bubble !== 1'b0) begin
      n_fail++; $display("FAIL halt_t4 halted=%b stage_en=%b pc_en=%b bubble=%b exp 1/0000/0/0", d_halted, d_stage_en, d_pc_en, d_bubble);
    end
    set_reader(3'd1);
    redirect = 1;
    #1;
    n_cmp++; if (d_flush_fd !== 1'b0 || d_stage_en !== 4'b0000) begin
      n_fail++; $display("FAIL halt_ignore flush=%b stage_en=%b exp 0/0000", d_flush_fd, d_stage_en);
    end
    tick();
    tick();
    n_cmp++; if (d_halted !== 1'b1 || d_pc_en !== 1'b0) begin
      n_fail++; $display("FAIL halt_hold halted=%b pc_en=%b exp 1/0", d_halted, d_pc_en);
    end
    do_reset();
    #1;
    n_cmp++; if (d_halted !== 1'b0 || d_stage_en !== 4'b1111 || d_pc_en !== 1'b1) begin
      n_fail++; $display("FAIL halt_rst halted=%b stage_en=%b pc_en=%b exp 0/1111/1", d_halted, d_stage_en, d_pc_en);
    end
  endtask

  // Self-dependent writer of r3 re-issued every free cycle: 6 of every 7 cycles stall on
  // the 8-stage no-bypass instance, 2 of every 3 on the 5-stage default.
  task automatic test_saturation();
    do_reset();
    set_writer(3'd3, 1'b0);
    dec_rs_used = 1; dec_rs_sel = 3'd3;
    for (int i = 0; i < 701; i++) tick();
    n_cmp++; if (s_stall_cnt !== 16'd600) begin n_fail++; $display("FAIL sat_mid8 got=%0d exp=600", s_stall_cnt); end
    n_cmp++; if (d_stall_cnt !== 16'd467) begin n_fail++; $display("FAIL sat_mid5 got=%0d exp=467", d_stall_cnt); end
    for (int i = 701; i < 76468; i++) tick();
    n_cmp++; if (s_stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got=%h exp=ffff", s_stall_cnt); end
    n_cmp++; if (d_stall_cnt !== 16'd50978) begin n_fail++; $display("FAIL sat_count5 got=%0d exp=50978", d_stall_cnt); end
    for (int i = 0; i < 14; i++) tick();
    n_cmp++; if (s_stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", s_stall_cnt); end
    idle();
  endtask

  task automatic test_rst_mid_stall();
    do_reset();
    set_writer(3'd3, 1'b0);
    tick();
    set_reader(3'd3);
    #1;
    n_cmp++; if (d_bubble !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre bubble=%b exp=1", d_bubble); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_cmp++; if (d_bubble !== 1'b0 || d_pc_en !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_sb_clear bubble=%b pc_en=%b exp 0/1", d_bubble, d_pc_en);
    end
    n_cmp++; if (s_bubble !== 1'b0) begin n_fail++; $display("FAIL rstmid_sb_clear8 bubble=%b exp=0", s_bubble); end
    n_cmp++; if (d_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt got=%0d exp=0", d_stall_cnt); end
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_raw();
    test_fwd();
    test_redirect();
    test_halt();
    test_rst_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
